act_quant_4bit: RTL

Streaming requantiser that sits directly upstream of the 4-bit tanh activation stage. It accumulates a fixed number of signed products per neuron, then scales the sum by an arithmetic right shift and saturates it to the 4-bit code the activation consumes. Results go out through a valid/ready port backed by a 2-entry output FIFO, so short stalls on the activation side do not stall the MAC stream.

---
 rtl/act_quant_4bit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/act_quant_4bit.sv
// act_quant_4bit: streaming requantiser feeding the 4-bit tanh stage.
// Sums N_TERMS signed input terms per neuron, applies an arithmetic right
// shift by SHIFT, saturates to a signed 4-bit code, and queues the code in a
// 2-entry output FIFO behind a valid/ready port.
//
// Build option: define ACT_QUANT_ROUND_EN for round-half-up before the
// shift; when it is undefined the shift truncates toward minus infinity.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  synchronous flush of the partial sum and sat_seen
//   in_valid/in_ready    input term handshake (in_ready is combinational)
//   in_data  [IN_W]      signed input term
//   out_valid/out_ready  output code handshake
//   out_code [4]         signed code at the FIFO head
//   sat_seen             sticky flag: some emitted code was clamped
module act_quant_4bit #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned SHIFT   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_code,
  output logic            sat_seen
);

  localparam int unsigned CNT_W = $clog2(N_TERMS);
  // One guard bit so the rounding offset can never wrap the sum.
  localparam int unsigned RW    = ACC_W + 1;

  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(N_TERMS - 1);
  localparam logic signed [RW-1:0] V_MAX = RW'(7);
  localparam logic signed [RW-1:0] V_MIN = RW'(-8);

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic [1:0]              fifo_cnt;
  logic [3:0]              tail_q;

  logic                    pop_c;
  logic                    is_last_c;
  logic                    accept_c;
  logic                    push_c;
  logic signed [ACC_W-1:0] term_ext_c;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [RW-1:0]    rounded_c;
  logic signed [RW-1:0]    scaled_c;
  logic                    sat_hi_c;
  logic                    sat_lo_c;
  logic [3:0]              code_c;

  logic [1:0]              fifo_cnt_d;
  logic [3:0]              head_d;
  logic [3:0]              tail_d;

  // Handshake and accumulation datapath.
  always_comb begin
    term_ext_c = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
    pop_c      = out_valid & out_ready;
    is_last_c  = (cnt == LAST);
    // Only the final term of a group needs FIFO space; a same-cycle pop frees it.
    in_ready   = !(is_last_c && (fifo_cnt == 2'd2) && !pop_c);
    accept_c   = in_valid & in_ready & ~clr;
    push_c     = accept_c & is_last_c;
    sum_c      = acc + term_ext_c;
`ifdef ACT_QUANT_ROUND_EN
    rounded_c  = {sum_c[ACC_W-1], sum_c} + RW'(2 ** (SHIFT - 1));
`else
    rounded_c  = {sum_c[ACC_W-1], sum_c};
`endif
    scaled_c   = rounded_c >>> SHIFT;
    sat_hi_c   = (scaled_c > V_MAX);
    sat_lo_c   = (scaled_c < V_MIN);
    if (sat_hi_c) begin
      code_c = 4'b0111;
    end else if (sat_lo_c) begin
      code_c = 4'b1000;
    end else begin
      code_c = scaled_c[3:0];
    end
  end

  // Two-entry FIFO next state; the head register drives out_code directly.
  always_comb begin
    fifo_cnt_d = fifo_cnt;
    head_d     = out_code;
    tail_d     = tail_q;
    case ({push_c, pop_c})
      2'b10: begin
        if (fifo_cnt == 2'd0) begin
          head_d = code_c;
        end else begin
          tail_d = code_c;
        end
        fifo_cnt_d = fifo_cnt + 2'd1;
      end
      2'b01: begin
        head_d     = tail_q;
        fifo_cnt_d = fifo_cnt - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt == 2'd1) begin
          head_d = code_c;
        end else begin
          head_d = tail_q;
          tail_d = code_c;
        end
      end
      default: begin
        fifo_cnt_d = fifo_cnt;
      end
    endcase
  end

  // Term counter, accumulator and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      sat_seen <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      acc      <= '0;
      sat_seen <= 1'b0;
    end else if (accept_c) begin
      if (is_last_c) begin
        cnt      <= '0;
        sat_seen <= sat_seen | sat_hi_c | sat_lo_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      acc <= (cnt == '0) ? term_ext_c : sum_c;
    end
  end

  // FIFO storage; clr deliberately leaves queued codes untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt  <= 2'd0;
      out_valid <= 1'b0;
      out_code  <= 4'b0000;
      tail_q    <= 4'b0000;
    end else begin
      fifo_cnt  <= fifo_cnt_d;
      out_valid <= (fifo_cnt_d != 2'd0);
      out_code  <= head_d;
      tail_q    <= tail_d;
    end
  end

endmodule
